// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: digit actions, FSM states
// and the per-mode digit count.
package booth_pkg;

    typedef enum logic [2:0] {
        ACT_ZERO = 3'd0,
        ACT_P1   = 3'd1,
        ACT_P2   = 3'd2,
        ACT_M1   = 3'd3,
        ACT_M2   = 3'd4
    } act_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    // Unsigned operands need one extra digit so the top digit is never negative.
    function automatic int unsigned num_digits(input int unsigned width, input logic is_signed);
        return is_signed ? (width / 2) : (width / 2 + 1);
    endfunction

endpackage

// File: rtl/booth_digit_encoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
// to the action applied to the multiplicand.
module booth_digit_encoder
    import booth_pkg::*;
(
    input  logic [2:0] digit_i,
    output act_e       act_o
);

    always_comb begin
        act_o = ACT_ZERO;
        unique case (digit_i)
            3'b000, 3'b111: act_o = ACT_ZERO;
            3'b001, 3'b010: act_o = ACT_P1;
            3'b011:         act_o = ACT_P2;
            3'b100:         act_o = ACT_M2;
            3'b101, 3'b110: act_o = ACT_M1;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier retiring one digit per clock, with
// valid/ready handshakes. Define BOOTH_ACC_EN to add the acc_in addend.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH / 2 + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
`ifdef BOOTH_ACC_EN
    input  logic [2*WIDTH-1:0]   acc_in,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned AW = 2 * WIDTH + 2;  // accumulator
    localparam int unsigned MW = WIDTH + 2;      // extended multiplicand
    localparam int unsigned BW = WIDTH + 3;      // multiplier plus b[-1]

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              signed_q, signed_d;
    logic [MW-1:0]     m_q, m_d;
    logic [BW-1:0]     mult_q, mult_d;
    logic [AW-1:0]     acc_q, acc_d;

    act_e              act;
    logic [MW:0]       m_ext;
    logic [MW:0]       term;
    logic [AW-1:0]     term_ext;
    logic [AW-1:0]     addend;
    logic [CNT_W:0]    shamt;
    logic [AW-1:0]     acc_init;
    logic              last_digit;

    booth_digit_encoder u_enc (
        .digit_i (mult_q[2:0]),
        .act_o   (act)
    );

    always_comb begin
        m_ext = {m_q[MW-1], m_q};
        term  = '0;
        unique case (act)
            ACT_P1:  term = m_ext;
            ACT_P2:  term = {m_q, 1'b0};
            ACT_M1:  term = -m_ext;
            ACT_M2:  term = -{m_q, 1'b0};
            default: term = '0;
        endcase
        term_ext   = {{(AW-MW-1){term[MW]}}, term};
        shamt      = {cnt_q, 1'b0};
        addend     = term_ext << shamt;
        last_digit = (cnt_q == CNT_W'(num_digits(WIDTH, signed_q) - 1));
    end

    always_comb begin
`ifdef BOOTH_ACC_EN
        acc_init = is_signed ? {{2{acc_in[2*WIDTH-1]}}, acc_in} : {2'b00, acc_in};
`else
        acc_init = '0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        m_d      = m_q;
        mult_d   = mult_q;
        acc_d    = acc_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = BUSY;
                    cnt_d    = '0;
                    signed_d = is_signed;
                    m_d      = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
                    mult_d   = is_signed ? {{2{b[WIDTH-1]}}, b, 1'b0} : {2'b00, b, 1'b0};
                    acc_d    = acc_init;
                end
            end
            BUSY: begin
                acc_d  = acc_q + addend;
                // Slide the next overlapping 3-bit window into mult_q[2:0].
                mult_d = {2'b00, mult_q[BW-1:2]};
                cnt_d  = cnt_q + 1'b1;
                if (last_digit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            m_q      <= '0;
            mult_q   <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            m_q      <= m_d;
            mult_q   <= mult_d;
            acc_q    <= acc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == DONE);
    assign product   = acc_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at WIDTH=8: vector table plus back-pressure
// and mid-operation reset sequences. Exercises acc_in when BOOTH_ACC_EN is defined.
module tb_booth_mult_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        is_signed;
    logic [15:0] acc_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int checks;
    int errors;

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic        vs;
        logic [15:0] vacc;
        logic [15:0] vexp;
        int          vlat;
    } vec_t;

    vec_t vecs[$];

    booth_mult_seq #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
`ifdef BOOTH_ACC_EN
        .acc_in    (acc_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic ts, input logic [15:0] tacc, input logic [15:0] texp,
                          input int tlat);
        int cyc;
        @(negedge clk);
        check($sformatf("%s in_ready", name), {31'd0, in_ready}, 32'd1);
        a         = ta;
        b         = tb_v;
        is_signed = ts;
        acc_in    = tacc;
        in_valid  = 1'b1;
        @(negedge clk);
        // Scramble operands after the accept; they must not matter.
        in_valid  = 1'b0;
        a         = ~ta;
        b         = 8'h5A;
        is_signed = ~ts;
        acc_in    = 16'h1234;
        check($sformatf("%s busy", name), {31'd0, busy}, 32'd1);
        cyc = 0;
        while (!out_valid && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s latency", name), cyc, tlat);
        check($sformatf("%s product", name), {16'd0, product}, {16'd0, texp});
        check($sformatf("%s busy_done", name), {31'd0, busy}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check($sformatf("%s consumed", name), {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int cyc;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        acc_in    = '0;

        vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h0000, 16'h4000, 4});
        vecs.push_back('{8'h7F, 8'hFF, 1'b1, 16'h0000, 16'hFF81, 4});
        vecs.push_back('{8'h00, 8'hB3, 1'b1, 16'h0000, 16'h0000, 4});
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'h0000, 16'hFE01, 5});
        vecs.push_back('{8'h80, 8'h02, 1'b0, 16'h0000, 16'h0100, 5});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0000, 16'h0001, 4});
        vecs.push_back('{8'hB3, 8'h5A, 1'b0, 16'h0000, 16'h3EEE, 5});
        vecs.push_back('{8'h80, 8'h7F, 1'b1, 16'h0000, 16'hC080, 4});
`ifdef BOOTH_ACC_EN
        vecs.push_back('{8'h03, 8'h04, 1'b1, 16'h0064, 16'h0070, 4});
        vecs.push_back('{8'h01, 8'h01, 1'b0, 16'hFFFF, 16'h0000, 5});
        vecs.push_back('{8'hFE, 8'h03, 1'b1, 16'h0000, 16'hFFFA, 4});
        vecs.push_back('{8'h02, 8'h03, 1'b1, 16'hFFFF, 16'h0005, 4});
`endif

        #1 rst_n = 1'b0;
        #2;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset product", {16'd0, product}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vs,
                   vecs[i].vacc, vecs[i].vexp, vecs[i].vlat);
        end

        // Back-pressure: in_valid stays high while the result is held.
        @(negedge clk);
        a = 8'h07; b = 8'h06; is_signed = 1'b1; acc_in = '0; in_valid = 1'b1;
        @(negedge clk);
        a = 8'h02; b = 8'h02;
        cyc = 0;
        while (!out_valid && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("bp latency", cyc, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp hold%0d product", i), {16'd0, product}, 32'h2A);
            check($sformatf("bp hold%0d in_ready", i), {31'd0, in_ready}, 32'd0);
            check($sformatf("bp hold%0d out_valid", i), {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp release in_ready", {31'd0, in_ready}, 32'd1);
        check("bp release out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp second accept busy", {31'd0, busy}, 32'd1);
        cyc = 0;
        while (!out_valid && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("bp second product", {16'd0, product}, 32'h4);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset two cycles into an operation.
        a = 8'h64; b = 8'h64; is_signed = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst mid out_valid", {31'd0, out_valid}, 32'd0);
        check("rst mid busy", {31'd0, busy}, 32'd0);
        check("rst mid product", {16'd0, product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst release in_ready", {31'd0, in_ready}, 32'd1);
        run_op("post_rst 3x5", 8'h03, 8'h05, 1'b1, 16'h0000, 16'h000F, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Iterative radix-4 Booth multiplier, parametrised in operand width, with valid/ready handshakes on both sides and a per-operation signed/unsigned mode. It retires one 3-bit Booth digit per clock. It is the sequential multiply engine that feeds the FMAC datapath's accumulate stage.

## Interface
- `WIDTH`, default 8: operand width in bits; must be even and ≥4.
- `CNT_W`, default `$clog2(WIDTH/2+2)`: width of the digit counter.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  multiplicand.
- `b`  in  WIDTH  multiplier.
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned; captured with the operands.
- `acc_in`  in  2*WIDTH  addend; present only with `BOOTH_ACC_EN`.
- `out_valid`  out  1  `product` is valid.
- `out_ready`  in  1  consumer accepts `product`.
- `product`  out  2*WIDTH  result.
- `busy`  out  1  high in the BUSY state.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - BUSY: digits are being retired.
  - DONE: `out_valid`=1.
- Transitions:
  - IDLE→BUSY on `in_valid && in_ready`. This captures `a`, `b`, `is_signed` (and `acc_in`) and clears the counter.
  - BUSY→DONE after the last digit.
  - DONE→IDLE on `out_ready`.
- Digit count:
  - Signed: N=WIDTH/2 digits.
  - Unsigned: N=WIDTH/2+1 digits. The multiplier is zero-extended by two bits, so the top digit is never negative.
- Digit i is formed from multiplier bits {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
- Digit action codes:
  - 000 and 111 → ZERO (0).
  - 001 and 010 → +M (1).
  - 011 → +2M (2).
  - 101 and 110 → −M (3).
  - 100 → −2M (4).
- M is the multiplicand, extended to WIDTH+2 bits: sign-extended when signed, zero-extended when unsigned. Digit i adds ±M or ±2M shifted left by 2i into the accumulator.
- The accumulator is 2*WIDTH+2 bits wide. `product` is the low 2*WIDTH bits.
- The result is exact in both modes: a·b, or a·b+acc_in with `BOOTH_ACC_EN`, taken modulo 2^(2·WIDTH).
- `product` holds its value from the DONE entry until the next accept. It is unchanged while `out_ready`=0.
- `in_valid` while not IDLE is ignored; there is no queuing.
- Changes to the operand inputs after the accept have no effect.

## Timing
- Reset values:
  - State = IDLE, so `in_ready`=1.
  - `out_valid`=0, `busy`=0, `product`=0, counter=0.
- Accept at edge k: `busy`=1 from k. `out_valid` rises at edge k+N and `busy` falls at the same edge.
- Latency: 4 cycles for signed operands and 5 for unsigned at WIDTH=8.
- The earliest next accept is the cycle after DONE is consumed.
- Throughput with `out_ready` tied high: one result every N+2 cycles.
- `out_valid` && `out_ready` at edge j → IDLE at j; `in_ready`=1 from j.
- If `rst_n` falls mid-BUSY or in DONE: everything returns immediately (asynchronously) to the reset values, and the result is discarded.
- `in_ready` is a registered state decode with no combinational path from `out_ready`.

## Configuration
- `BOOTH_ACC_EN` defined:
  - The `acc_in` port exists and is captured at accept.
  - The accumulator is initialised to the sign-extended `acc_in` when signed, or the zero-extended `acc_in` when unsigned.
  - The result is a·b+acc_in, wrapping modulo 2^(2·WIDTH).
  - Latency is unchanged.
- `BOOTH_ACC_EN` undefined: the port is absent, the accumulator initialises to 0, and the result is a·b.

## Structure
- Package `booth_pkg` holds:
  - The action enum: ACT_ZERO=0, ACT_P1=1, ACT_P2=2, ACT_M1=3, ACT_M2=4, 3 bits.
  - The state enum: IDLE, BUSY, DONE.
  - A function for the digit count given WIDTH and the signed mode.
- One sub-module, `booth_digit_encoder`: a combinational map from 3 bits to an action code, instantiated once on the current digit window.
- The shift/add datapath and the FSM live in `booth_mult_seq`.

## Test plan
All scenarios use WIDTH=8.
- Signed −128 × −128 → `product`=0x4000, `out_valid` 4 cycles after accept.
- Signed 127 × −1 → 0xFF81; signed 0 × −77 → 0x0000.
- Unsigned 255 × 255 → 0xFE01, `out_valid` 5 cycles after accept; unsigned 0x80 × 0x02 → 0x0100.
- Back-pressure: hold `out_ready`=0 for 3 cycles after DONE, with `in_valid`=1 throughout → `product` stable, `in_ready`=0, no second accept. Then release `out_ready` → accept occurs the following cycle.
- Reset mid-BUSY (2 cycles after accept) → `out_valid`=0, `busy`=0, `product`=0 at once; `in_ready`=1 after release; a fresh 3×5 gives 15.
- With `BOOTH_ACC_EN`:
  - signed 3×4 + 100 → 112;
  - unsigned 1×1 + 0xFFFF → 0x0000 (wrap);
  - signed −2×3 + 0x0000 → 0xFFFA.
